// File: rtl/adc_acq_pkg.sv
// Shared definitions for the ADC acquisition sequencer: FSM state encoding,
// the 4-bit mux tag values used by the downstream output mux, and bus widths.
package adc_acq_pkg;

  localparam int BURST_W = 23;
  localparam int WFM_W   = 12;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FILL_HDR = 3'd1,
    ST_WFM_HDR  = 3'd2,
    ST_DATA     = 3'd3,
    ST_GAP      = 3'd4,
    ST_CKSUM    = 3'd5,
    ST_DONE     = 3'd6
  } acq_state_e;

  localparam logic [3:0] TAG_NONE     = 4'd0;
  localparam logic [3:0] TAG_FILL_HDR = 4'd1;
  localparam logic [3:0] TAG_WFM_HDR  = 4'd2;
  localparam logic [3:0] TAG_DATA     = 4'd3;
  localparam logic [3:0] TAG_CKSUM    = 4'd4;

  // Mux tag driven while the sequencer sits in a given state.
  function automatic logic [3:0] state_tag(input acq_state_e st);
    logic [3:0] tag;
    case (st)
      ST_FILL_HDR: tag = TAG_FILL_HDR;
      ST_WFM_HDR:  tag = TAG_WFM_HDR;
      ST_DATA:     tag = TAG_DATA;
      ST_CKSUM:    tag = TAG_CKSUM;
      default:     tag = TAG_NONE;
    endcase
    return tag;
  endfunction

endpackage

// File: rtl/adc_acq_sequencer_if.sv
// Control/status bundle between the acquisition controller (master) and the
// sequencer (slave): trigger and fill parameters in, mux selects and status out.
interface adc_acq_sequencer_if #(
  parameter int GAP_W = 22
);
  import adc_acq_pkg::*;

  logic                 trigger;
  logic                 fifo_almost_full;
  logic [BURST_W-1:0]   num_fill_bursts;
  logic [WFM_W-1:0]     num_waveforms;
  logic [GAP_W-1:0]     waveform_gap;

  logic                 select_fill_hdr;
  logic                 select_waveform_hdr;
  logic                 select_dat;
  logic                 select_checksum;
  logic                 checksum_update;
  logic [WFM_W-1:0]     current_waveform_num;
  logic                 acq_wr_en;
  logic                 busy;
  logic                 fill_done;
  logic                 trig_rejected;

  modport master (
    output trigger, fifo_almost_full, num_fill_bursts, num_waveforms, waveform_gap,
    input  select_fill_hdr, select_waveform_hdr, select_dat, select_checksum,
    input  checksum_update, current_waveform_num, acq_wr_en, busy, fill_done,
    input  trig_rejected
  );

  modport slave (
    input  trigger, fifo_almost_full, num_fill_bursts, num_waveforms, waveform_gap,
    output select_fill_hdr, select_waveform_hdr, select_dat, select_checksum,
    output checksum_update, current_waveform_num, acq_wr_en, busy, fill_done,
    output trig_rejected
  );

endinterface

// File: rtl/acq_down_counter.sv
// Loadable down counter with a zero flag. Decrement saturates at zero so a
// stray decrement can never wrap into a huge remaining count.
module acq_down_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] count_r;

  // Count register: load has priority over decrement.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r <= '0;
    end else if (load) begin
      count_r <= load_val;
    end else if (dec && (count_r != '0)) begin
      count_r <= count_r - ONE;
    end else begin
      count_r <= count_r;
    end
  end

  assign zero = (count_r == '0);

endmodule

// File: rtl/adc_acq_sequencer.sv
// ADC acquisition sequencer: on an accepted trigger, walks the fill header,
// per-waveform headers, data bursts, inter-waveform gaps and the checksum,
// driving one-hot mux selects and a write enable one cycle behind them.
module adc_acq_sequencer
  import adc_acq_pkg::*;
#(
  parameter int WFM_MAX = 4095,
  parameter int GAP_W   = 22
) (
  input  logic               clk,
  input  logic               reset,
  adc_acq_sequencer_if.slave bus
);

  localparam logic [WFM_W-1:0]   WFM_MAX_C = WFM_W'(WFM_MAX);
  localparam logic [WFM_W-1:0]   WFM_ONE   = WFM_W'(1);
  localparam logic [BURST_W-1:0] BURST_ONE = BURST_W'(1);
  localparam logic [GAP_W-1:0]   GAP_ONE   = GAP_W'(1);

  acq_state_e         state_r, next_state_s, eow_state_s;
  logic [BURST_W-1:0] bursts_lat_r;
  logic [WFM_W-1:0]   wfm_lat_r, wfm_eff_s, wfm_num_r;
  logic [GAP_W-1:0]   gap_lat_r;
  logic               accept_s, last_wfm_s;
  logic               eow_gap_load_s, eow_inc_s;
  logic               burst_load_s, burst_dec_s, burst_zero_s;
  logic               gap_load_s, gap_dec_s, gap_zero_s;
  logic               wfm_inc_s;
  logic [3:0]         next_tag_s;

  logic sel_fill_r, sel_wfm_r, sel_dat_r, sel_ck_r, cks_upd_r;
  logic wr_en_r, busy_r, done_r, rej_r;

  // Triggers are only taken in IDLE while the write FIFO has headroom.
  assign accept_s   = (state_r == ST_IDLE) && bus.trigger && !bus.fifo_almost_full;
  assign last_wfm_s = (wfm_num_r == (wfm_lat_r - WFM_ONE));
  assign next_tag_s = state_tag(next_state_s);

  // Effective waveform count: zero means one, oversize clamps to WFM_MAX.
  always_comb begin
    wfm_eff_s = bus.num_waveforms;
    if (bus.num_waveforms == '0) begin
      wfm_eff_s = WFM_ONE;
    end else if (bus.num_waveforms > WFM_MAX_C) begin
      wfm_eff_s = WFM_MAX_C;
    end else begin
      wfm_eff_s = bus.num_waveforms;
    end
  end

  // Where to go once a waveform's data is finished (or skipped).
  always_comb begin
    eow_state_s    = ST_CKSUM;
    eow_gap_load_s = 1'b0;
    eow_inc_s      = 1'b0;
    if (last_wfm_s) begin
      eow_state_s = ST_CKSUM;
    end else if (gap_lat_r == '0) begin
      eow_state_s = ST_WFM_HDR;
      eow_inc_s   = 1'b1;
    end else begin
      eow_state_s    = ST_GAP;
      eow_gap_load_s = 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state and counter control. Counters are loaded with count-1 so the
  // zero flag marks the last DATA/GAP cycle.
  always_comb begin
    next_state_s = state_r;
    burst_load_s = 1'b0;
    burst_dec_s  = 1'b0;
    gap_load_s   = 1'b0;
    gap_dec_s    = 1'b0;
    wfm_inc_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          next_state_s = ST_FILL_HDR;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_FILL_HDR: begin
        next_state_s = ST_WFM_HDR;
      end
      ST_WFM_HDR: begin
        if (bursts_lat_r != '0) begin
          next_state_s = ST_DATA;
          burst_load_s = 1'b1;
        end else begin
          next_state_s = eow_state_s;
          gap_load_s   = eow_gap_load_s;
          wfm_inc_s    = eow_inc_s;
        end
      end
      ST_DATA: begin
        if (burst_zero_s) begin
          next_state_s = eow_state_s;
          gap_load_s   = eow_gap_load_s;
          wfm_inc_s    = eow_inc_s;
        end else begin
          burst_dec_s = 1'b1;
        end
      end
      ST_GAP: begin
        if (gap_zero_s) begin
          next_state_s = ST_WFM_HDR;
          wfm_inc_s    = 1'b1;
        end else begin
          gap_dec_s = 1'b1;
        end
      end
      ST_CKSUM: begin
        next_state_s = ST_DONE;
      end
      ST_DONE: begin
        next_state_s = ST_IDLE;
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  acq_down_counter #(.W(BURST_W)) u_burst_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (burst_load_s),
    .load_val (bursts_lat_r - BURST_ONE),
    .dec      (burst_dec_s),
    .zero     (burst_zero_s)
  );

  acq_down_counter #(.W(GAP_W)) u_gap_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (gap_load_s),
    .load_val (gap_lat_r - GAP_ONE),
    .dec      (gap_dec_s),
    .zero     (gap_zero_s)
  );

  // Fill parameters are captured only on an accepted trigger.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bursts_lat_r <= '0;
      wfm_lat_r    <= '0;
      gap_lat_r    <= '0;
    end else if (accept_s) begin
      bursts_lat_r <= bus.num_fill_bursts;
      wfm_lat_r    <= wfm_eff_s;
      gap_lat_r    <= bus.waveform_gap;
    end else begin
      bursts_lat_r <= bursts_lat_r;
      wfm_lat_r    <= wfm_lat_r;
      gap_lat_r    <= gap_lat_r;
    end
  end

  // Waveform index: cleared entering FILL_HDR, bumped entering each later WFM_HDR.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wfm_num_r <= '0;
    end else if (accept_s) begin
      wfm_num_r <= '0;
    end else if (wfm_inc_s) begin
      wfm_num_r <= wfm_num_r + WFM_ONE;
    end else begin
      wfm_num_r <= wfm_num_r;
    end
  end

  // Registered outputs, decoded from the upcoming state so they line up with it;
  // write enable trails the selects by one cycle to match the registered mux.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_fill_r <= 1'b0;
      sel_wfm_r  <= 1'b0;
      sel_dat_r  <= 1'b0;
      sel_ck_r   <= 1'b0;
      cks_upd_r  <= 1'b0;
      wr_en_r    <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      rej_r      <= 1'b0;
    end else begin
      sel_fill_r <= (next_tag_s == TAG_FILL_HDR);
      sel_wfm_r  <= (next_tag_s == TAG_WFM_HDR);
      sel_dat_r  <= (next_tag_s == TAG_DATA);
      sel_ck_r   <= (next_tag_s == TAG_CKSUM);
      cks_upd_r  <= (next_tag_s == TAG_DATA);
      wr_en_r    <= sel_fill_r | sel_wfm_r | sel_dat_r | sel_ck_r;
      busy_r     <= (next_state_s != ST_IDLE);
      done_r     <= (next_state_s == ST_DONE);
      rej_r      <= bus.trigger && !accept_s;
    end
  end

  assign bus.select_fill_hdr      = sel_fill_r;
  assign bus.select_waveform_hdr  = sel_wfm_r;
  assign bus.select_dat           = sel_dat_r;
  assign bus.select_checksum      = sel_ck_r;
  assign bus.checksum_update      = cks_upd_r;
  assign bus.current_waveform_num = wfm_num_r;
  assign bus.acq_wr_en            = wr_en_r;
  assign bus.busy                 = busy_r;
  assign bus.fill_done            = done_r;
  assign bus.trig_rejected        = rej_r;

endmodule
